// File: rtl/dds_sequencer.sv
// Sequencer front-end for the DDS tone engine: clears the engine, streams the
// THETA/DELTA/AMPL tables into it, then runs it and strobes each sample.
module dds_sequencer #(
  parameter int SIG_WIDTH  = 16,
  parameter int N_TONES    = 8,
  parameter int CLR_CYCLES = 2,
  parameter int IDLE_ADDR  = 3
) (
  input  logic                 clk,
  input  logic                 a_rst_n,
  input  logic                 i_load,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_cfg_valid,
  output logic                 o_cfg_ready,
  input  logic [SIG_WIDTH-1:0] i_cfg_data,
  output logic [31:0]          o_dds_addrs,
  output logic [SIG_WIDTH-1:0] o_dds_fifo_data,
  output logic                 o_dds_rst,
  output logic                 o_dds_start,
  output logic                 o_dds_sample_en,
  output logic                 o_smp_valid,
  output logic                 o_loaded,
  output logic                 o_busy
);

  localparam int BW = (N_TONES > 1) ? $clog2(N_TONES) : 1;
  localparam int CW = $clog2(CLR_CYCLES + 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(N_TONES - 1);
  localparam logic [CW-1:0] LAST_CLR = CW'(CLR_CYCLES - 1);
  localparam logic [31:0]   IDLE_A   = 32'(IDLE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD_TH, S_LOAD_DL, S_LOAD_AM, S_LOADED, S_RUN
  } state_t;

  state_t                r_state, w_next_state;
  logic [BW-1:0]         r_beat, w_beat_next;
  logic [CW-1:0]         r_clr_cnt, w_clr_next;
  logic [BW-1:0]         r_smp_cnt, w_smp_next;
  logic                  r_warm;
  logic                  w_loading, w_beat;
  logic [31:0]           w_tab_addr;

  logic                  r_cfg_ready, r_dds_rst, r_dds_start, r_sample_en;
  logic                  r_smp_valid, r_loaded, r_busy;
  logic [31:0]           r_addrs;
  logic [SIG_WIDTH-1:0]  r_fifo_data;

  assign w_loading = (r_state inside {S_LOAD_TH, S_LOAD_DL, S_LOAD_AM});
  // A beat coinciding with i_load is dropped: the reload discards it anyway.
  assign w_beat    = w_loading && i_cfg_valid && !i_load;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_beat_next  = r_beat;
    w_clr_next   = r_clr_cnt;
    w_smp_next   = '0;
    w_tab_addr   = IDLE_A;
    if (i_load) begin
      w_next_state = S_CLEAR;
      w_clr_next   = '0;
      w_beat_next  = '0;
    end else begin
      unique case (r_state)
        S_CLEAR: begin
          if (r_clr_cnt == LAST_CLR) w_next_state = S_LOAD_TH;
          else                       w_clr_next   = r_clr_cnt + 1'b1;
        end
        S_LOAD_TH, S_LOAD_DL, S_LOAD_AM: begin
          if (w_beat) begin
            if (r_beat == LAST_IDX) begin
              w_beat_next = '0;
              case (r_state)
                S_LOAD_TH: w_next_state = S_LOAD_DL;
                S_LOAD_DL: w_next_state = S_LOAD_AM;
                default:   w_next_state = S_LOADED;
              endcase
            end else begin
              w_beat_next = r_beat + 1'b1;
            end
          end
        end
        S_LOADED: if (i_start && !i_stop) w_next_state = S_RUN;
        S_RUN: begin
          if (i_stop) w_next_state = S_LOADED;
          else        w_smp_next   = (r_smp_cnt == LAST_IDX) ? '0 : r_smp_cnt + 1'b1;
        end
        default: ;
      endcase
    end
    case (r_state)
      S_LOAD_TH: w_tab_addr = 32'd0;
      S_LOAD_DL: w_tab_addr = 32'd1;
      S_LOAD_AM: w_tab_addr = 32'd2;
      default:   w_tab_addr = IDLE_A;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_clr_cnt   <= '0;
      r_smp_cnt   <= '0;
      r_warm      <= 1'b0;
      r_cfg_ready <= 1'b0;
      r_dds_rst   <= 1'b0;
      r_dds_start <= 1'b0;
      r_sample_en <= 1'b0;
      r_smp_valid <= 1'b0;
      r_loaded    <= 1'b0;
      r_busy      <= 1'b0;
      r_addrs     <= IDLE_A;
      r_fifo_data <= '0;
    end else begin
      r_state     <= w_next_state;
      r_beat      <= w_beat_next;
      r_clr_cnt   <= w_clr_next;
      r_smp_cnt   <= w_smp_next;
      r_cfg_ready <= (w_next_state inside {S_LOAD_TH, S_LOAD_DL, S_LOAD_AM});
      r_busy      <= (w_next_state inside {S_CLEAR, S_LOAD_TH, S_LOAD_DL, S_LOAD_AM});
      r_dds_rst   <= (w_next_state == S_CLEAR);
      r_dds_start <= (w_next_state == S_RUN);
      r_loaded    <= (w_next_state inside {S_LOADED, S_RUN});
      r_addrs     <= w_beat ? w_tab_addr : IDLE_A;
      r_fifo_data <= w_beat ? i_cfg_data : '0;
      r_sample_en <= (w_next_state == S_RUN) && (w_smp_next == LAST_IDX);
      // The first accumulation after RUN entry is pipeline warm-up, not a sample.
      r_smp_valid <= r_sample_en && r_warm;
      r_warm      <= (w_next_state == S_RUN) && (r_warm || r_sample_en);
    end
  end

  assign o_cfg_ready     = r_cfg_ready;
  assign o_dds_addrs     = r_addrs;
  assign o_dds_fifo_data = r_fifo_data;
  assign o_dds_rst       = r_dds_rst;
  assign o_dds_start     = r_dds_start;
  assign o_dds_sample_en = r_sample_en;
  assign o_smp_valid     = r_smp_valid;
  assign o_loaded        = r_loaded;
  assign o_busy          = r_busy;

endmodule

// File: tb/tb_dds_sequencer.sv
// Self-checking bench for dds_sequencer (N_TONES=4, CLR_CYCLES=2): vector table,
// directed corner sequences, then random stimulus against a behavioural model.
module tb_dds_sequencer;

  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          a_rst_n;
  logic          i_load, i_start, i_stop, i_cfg_valid;
  logic [SW-1:0] i_cfg_data;
  logic          o_cfg_ready, o_dds_rst, o_dds_start, o_dds_sample_en;
  logic          o_smp_valid, o_loaded, o_busy;
  logic [31:0]   o_dds_addrs;
  logic [SW-1:0] o_dds_fifo_data;

  int n_checks = 0;
  int n_fail   = 0;

  dds_sequencer #(.SIG_WIDTH(SW), .N_TONES(4), .CLR_CYCLES(2), .IDLE_ADDR(3)) dut (
    .clk(clk), .a_rst_n(a_rst_n), .i_load(i_load), .i_start(i_start), .i_stop(i_stop),
    .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready), .i_cfg_data(i_cfg_data),
    .o_dds_addrs(o_dds_addrs), .o_dds_fifo_data(o_dds_fifo_data), .o_dds_rst(o_dds_rst),
    .o_dds_start(o_dds_start), .o_dds_sample_en(o_dds_sample_en), .o_smp_valid(o_smp_valid),
    .o_loaded(o_loaded), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic ld, st, sp, vl;
    logic [SW-1:0] d;
    logic [31:0] e_addr;
    logic [SW-1:0] e_data;
    logic e_rst, e_start, e_sen, e_sval, e_rdy, e_ldd, e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ld, logic st, logic sp, logic vl, logic [SW-1:0] d,
                              logic [31:0] ea, logic [SW-1:0] ed, logic er, logic es,
                              logic esn, logic esv, logic erd, logic eld, logic eb);
    vec_t v;
    v.ld = ld; v.st = st; v.sp = sp; v.vl = vl; v.d = d;
    v.e_addr = ea; v.e_data = ed; v.e_rst = er; v.e_start = es; v.e_sen = esn;
    v.e_sval = esv; v.e_rdy = erd; v.e_ldd = eld; v.e_busy = eb;
    return v;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},   o_dds_addrs, 3);
    check({tag, "_data"},   o_dds_fifo_data, 0);
    check({tag, "_rst"},    o_dds_rst, 0);
    check({tag, "_start"},  o_dds_start, 0);
    check({tag, "_sen"},    o_dds_sample_en, 0);
    check({tag, "_sval"},   o_smp_valid, 0);
    check({tag, "_ready"},  o_cfg_ready, 0);
    check({tag, "_loaded"}, o_loaded, 0);
    check({tag, "_busy"},   o_busy, 0);
  endtask

  // Behavioural model: tracks clear cycles left, words accepted and run age.
  int   m_clr, m_words, m_runc;
  bit   m_loading, m_tables, m_running;
  logic [31:0]   e_addr;
  logic [SW-1:0] e_data;
  logic          e_sval;

  task automatic model_reset();
    m_clr = 0; m_words = 0; m_runc = 0;
    m_loading = 0; m_tables = 0; m_running = 0;
    e_addr = 3; e_data = '0; e_sval = 0;
  endtask

  task automatic model_step(input logic ld, input logic st, input logic sp,
                            input logic vl, input logic [SW-1:0] d);
    logic [31:0] na;
    logic [SW-1:0] nd;
    logic nv;
    nv = m_running && (m_runc % 4 == 3) && (m_runc >= 7);
    na = 3; nd = '0;
    if (ld) begin
      m_clr = 2; m_loading = 0; m_words = 0; m_tables = 0; m_running = 0;
    end else if (m_clr > 0) begin
      m_clr--;
      if (m_clr == 0) begin m_loading = 1; m_words = 0; end
    end else if (m_loading) begin
      if (vl) begin
        na = 32'(m_words / 4); nd = d; m_words++;
        if (m_words == 12) begin m_loading = 0; m_tables = 1; end
      end
    end else if (m_running) begin
      if (sp) m_running = 0; else m_runc++;
    end else if (m_tables && st && !sp) begin
      m_running = 1; m_runc = 0;
    end
    e_addr = na; e_data = nd; e_sval = nv;
  endtask

  function automatic logic [63:0] pack_dut();
    return {33'd0, o_dds_addrs[7:0], o_dds_fifo_data, o_dds_rst, o_dds_start,
            o_dds_sample_en, o_smp_valid, o_cfg_ready, o_loaded, o_busy};
  endfunction

  function automatic logic [63:0] pack_model();
    logic sen, busy;
    sen  = m_running && (m_runc % 4 == 3);
    busy = (m_clr > 0) || m_loading;
    return {33'd0, e_addr[7:0], e_data, m_clr > 0, m_running, sen, e_sval,
            m_loading, m_tables, busy};
  endfunction

  initial begin
    i_load = 0; i_start = 0; i_stop = 0; i_cfg_valid = 0; i_cfg_data = '0;
    a_rst_n = 0;
    repeat (3) @(negedge clk);
    a_rst_n = 1;

    // Idle after reset
    repeat (10) @(negedge clk);
    check_reset_vals("idle");

    // Vector table: clear, 12-beat load, run, stop, restart
    vecs.push_back(mk(1, 0, 0, 0, 16'h0,    3, 0, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 16'hDEAD, 3, 0, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 16'hBEEF, 3, 0, 0, 0, 0, 0, 1, 0, 1));
    for (int k = 1; k <= 12; k++)
      vecs.push_back(mk(0, 0, 0, 1, SW'(k), 32'((k - 1) / 4), SW'(k), 0, 0, 0, 0,
                        k < 12, k == 12, k < 12));
    vecs.push_back(mk(0, 1, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 1, 0));
    for (int c = 1; c <= 12; c++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 1, c % 4 == 3, (c % 4 == 0) && c >= 8, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 1, 0));
    for (int c = 1; c <= 8; c++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 1, c % 4 == 3, c == 8, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0));

    foreach (vecs[i]) begin
      i_load = vecs[i].ld; i_start = vecs[i].st; i_stop = vecs[i].sp;
      i_cfg_valid = vecs[i].vl; i_cfg_data = vecs[i].d;
      @(negedge clk);
      check($sformatf("vec%0d_addr", i),   o_dds_addrs,     vecs[i].e_addr);
      check($sformatf("vec%0d_data", i),   o_dds_fifo_data, vecs[i].e_data);
      check($sformatf("vec%0d_rst", i),    o_dds_rst,       vecs[i].e_rst);
      check($sformatf("vec%0d_start", i),  o_dds_start,     vecs[i].e_start);
      check($sformatf("vec%0d_sen", i),    o_dds_sample_en, vecs[i].e_sen);
      check($sformatf("vec%0d_sval", i),   o_smp_valid,     vecs[i].e_sval);
      check($sformatf("vec%0d_ready", i),  o_cfg_ready,     vecs[i].e_rdy);
      check($sformatf("vec%0d_loaded", i), o_loaded,        vecs[i].e_ldd);
      check($sformatf("vec%0d_busy", i),   o_busy,          vecs[i].e_busy);
    end
    i_load = 0; i_start = 0; i_stop = 0; i_cfg_valid = 0;

    // Load with valid toggling: gap cycles must not shift any buffer
    begin
      int  cnt[3];
      int  beats;
      bit  prev_beat;
      int  prev_idx;
      cnt = '{0, 0, 0}; beats = 0; prev_beat = 0; prev_idx = 0;
      i_load = 1;
      @(negedge clk);
      i_load = 0;
      for (int cyc = 0; cyc < 80; cyc++) begin
        check("toggle_addr", o_dds_addrs, prev_beat ? 32'(prev_idx) : 32'd3);
        if (o_dds_addrs < 3) cnt[o_dds_addrs] = cnt[o_dds_addrs] + 1;
        if (o_loaded) break;
        i_cfg_valid = (cyc % 2 == 1);
        i_cfg_data  = SW'(16'h100 + cyc);
        prev_beat = i_cfg_valid && o_cfg_ready;
        prev_idx  = beats / 4;
        if (prev_beat) beats++;
        @(negedge clk);
      end
      i_cfg_valid = 0;
      check("toggle_loaded", o_loaded, 1);
      check("toggle_th_writes", cnt[0], 4);
      check("toggle_dl_writes", cnt[1], 4);
      check("toggle_am_writes", cnt[2], 4);
    end

    // Stop at run cycle 5, then resume without reload
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    for (int c = 0; c <= 5; c++) begin
      check("stop_run_start", o_dds_start, 1);
      check("stop_run_sen", o_dds_sample_en, c == 3);
      if (c == 5) i_stop = 1;
      @(negedge clk);
      i_stop = 0;
    end
    check("stop_start_low", o_dds_start, 0);
    check("stop_loaded", o_loaded, 1);
    @(negedge clk);
    check("stop_no_sen_c7", o_dds_sample_en, 0);
    check("stop_no_sval", o_smp_valid, 0);
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    for (int c = 0; c <= 8; c++) begin
      check("resume_start", o_dds_start, 1);
      check("resume_sen", o_dds_sample_en, c % 4 == 3);
      check("resume_sval", o_smp_valid, c == 8);
      @(negedge clk);
    end

    // i_load beats i_start in RUN; then async reset in the middle of LOAD_DL
    i_load = 1; i_start = 1;
    @(negedge clk);
    i_load = 0; i_start = 0;
    check("ldrun_rst", o_dds_rst, 1);
    check("ldrun_start", o_dds_start, 0);
    check("ldrun_busy", o_busy, 1);
    check("ldrun_loaded", o_loaded, 0);
    i_cfg_valid = 1; i_cfg_data = 16'h55AA;
    for (int k = 0; k < 20 && o_dds_addrs != 1; k++) @(negedge clk);
    check("mid_dl_addr", o_dds_addrs, 1);
    check("mid_dl_ready", o_cfg_ready, 1);
    #2 a_rst_n = 0;
    #1 check_reset_vals("async_rst");
    i_cfg_valid = 0;
    @(negedge clk);
    a_rst_n = 1;

    // Randomized stimulus against the model
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic ld, st, sp, vl;
      logic [SW-1:0] d;
      check("rand_outputs", pack_dut(), pack_model());
      ld = ($urandom_range(99) < 2);
      st = ($urandom_range(99) < 10);
      sp = ($urandom_range(99) < 3);
      vl = ($urandom_range(99) < 60);
      d  = SW'($urandom);
      i_load = ld; i_start = st; i_stop = sp; i_cfg_valid = vl; i_cfg_data = d;
      model_step(ld, st, sp, vl, d);
      @(negedge clk);
    end
    check("rand_final", pack_dut(), pack_model());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
